// File: rtl/pciecfg_pkg.sv
// Shared types and constants for the PCIe config-over-UDP receive path.
package pciecfg_pkg;

    typedef struct packed {
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [15:0] src_port;
        logic [7:0]  opcode;
        logic [3:0]  byte_mask;
        logic [9:0]  dwaddr;
        logic [31:0] data;
    } pciecfg_pkt_t;

    typedef struct packed {
        logic         data_valid;
        pciecfg_pkt_t pkt;
    } FIFO_PCIECFG_T;

    localparam logic [7:0]  PCIECFG_OPC_RD = 8'h00;
    localparam logic [7:0]  PCIECFG_OPC_WR = 8'h01;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

    typedef enum logic [1:0] {StSync, StIdle, StHdr, StDrop} rx_state_e;

    function automatic logic [7:0] beat_byte(input logic [63:0] beat, input int unsigned lane);
        return beat[8*lane +: 8];
    endfunction

endpackage

// File: rtl/pciecfg_stat_cnt.sv
// 32-bit saturating event counter with synchronous clear.
module pciecfg_stat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pciecfg_rx.sv
// Parses 64-bit Ethernet beats into PCIe config requests for the request FIFO.
// Optional frame statistics are built only when PCIECFG_RX_STATS_EN is defined.
module pciecfg_rx
    import pciecfg_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_0A01,
    parameter logic [15:0] UDP_PORT = 16'd3072
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   eth_rx_tdata,
    input  logic [7:0]    eth_rx_tkeep,
    input  logic          eth_rx_tvalid,
    input  logic          eth_rx_tlast,
    input  logic          eth_rx_tuser,
    output logic          fifo_pciecfg_i_wr_en,
    input  logic          fifo_pciecfg_i_full,
    output FIFO_PCIECFG_T fifo_pciecfg_i_din,
    output logic [31:0]   stat_rx_ok,
    output logic [31:0]   stat_rx_drop
);

    rx_state_e     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    pciecfg_pkt_t  pkt_q, pkt_d;
    logic          wr_en_q, wr_en_d;
    FIFO_PCIECFG_T din_q, din_d;
    logic          drop_inc;
    logic          check_ok;
    logic          opc_ok;
    logic [7:0]    b [8];

    // Byte enables carry no extra information: length is implied by the beat count.
    logic unused_tkeep;
    assign unused_tkeep = ^eth_rx_tkeep;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            b[i] = beat_byte(eth_rx_tdata, i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pkt_d    = pkt_q;
        wr_en_d  = 1'b0;
        din_d    = din_q;
        din_d.data_valid = 1'b0;
        drop_inc = 1'b0;
        check_ok = 1'b1;
        opc_ok   = 1'b0;

        if (eth_rx_tvalid) begin
            unique case (state_q)
                StSync: begin
                    if (eth_rx_tlast) state_d = StIdle;
                end
                StIdle: begin
                    pkt_d.src_mac[47:32] = {b[6], b[7]};
                    if (eth_rx_tlast) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = StHdr;
                        cnt_d   = 3'd1;
                    end
                end
                StHdr: begin
                    case (cnt_q)
                        3'd1: begin
                            pkt_d.src_mac[31:0] = {b[0], b[1], b[2], b[3]};
                            check_ok = ({b[4], b[5]} == ETHERTYPE_IPV4) && (b[6] == IPV4_VER_IHL);
                        end
                        3'd2: check_ok = (b[7] == IP_PROTO_UDP);
                        3'd3: begin
                            pkt_d.src_ip = {b[2], b[3], b[4], b[5]};
                            check_ok = ({b[6], b[7]} == LOCAL_IP[31:16]);
                        end
                        3'd4: begin
                            pkt_d.src_port = {b[2], b[3]};
                            check_ok = ({b[0], b[1]} == LOCAL_IP[15:0]) &&
                                       ({b[4], b[5]} == UDP_PORT);
                        end
                        3'd5: begin
                            pkt_d.opcode     = b[2];
                            pkt_d.byte_mask  = b[3][3:0];
                            pkt_d.dwaddr     = {b[4][1:0], b[5]};
                            pkt_d.data[31:16] = {b[6], b[7]};
                            check_ok = (b[4][7:2] == 6'd0);
                        end
                        3'd6: pkt_d.data[15:0] = {b[0], b[1]};
                        default: ;
                    endcase

                    // Saturate so frames longer than eight beats still qualify on tlast.
                    if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;

                    opc_ok = (pkt_d.opcode == PCIECFG_OPC_RD) || (pkt_d.opcode == PCIECFG_OPC_WR);

                    if (eth_rx_tlast) begin
                        state_d = StIdle;
                        if (check_ok && (cnt_q >= 3'd6) && opc_ok && !eth_rx_tuser &&
                            !fifo_pciecfg_i_full) begin
                            wr_en_d          = 1'b1;
                            din_d.data_valid = 1'b1;
                            din_d.pkt        = pkt_d;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end else if (!check_ok) begin
                        state_d = StDrop;
                    end
                end
                StDrop: begin
                    if (eth_rx_tlast) begin
                        state_d  = StIdle;
                        drop_inc = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSync;
            cnt_q   <= '0;
            pkt_q   <= '0;
            wr_en_q <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            wr_en_q <= wr_en_d;
            din_q   <= din_d;
        end
    end

    assign fifo_pciecfg_i_wr_en = wr_en_q;
    assign fifo_pciecfg_i_din   = din_q;

`ifdef PCIECFG_RX_STATS_EN
    pciecfg_stat_cnt u_stat_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_en_d),
        .count (stat_rx_ok)
    );

    pciecfg_stat_cnt u_stat_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (stat_rx_drop)
    );
`else
    logic unused_stat_inc;
    assign unused_stat_inc = wr_en_d ^ drop_inc;
    assign stat_rx_ok      = 32'h0;
    assign stat_rx_drop    = 32'h0;
`endif

endmodule

// File: tb/tb_pciecfg_rx.sv
// Randomized bench for pciecfg_rx against a frame-level acceptance model.
module tb_pciecfg_rx;
    import pciecfg_pkg::*;

    localparam logic [31:0] LIP   = 32'hC0A8_0A01;
    localparam logic [15:0] LPORT = 16'd3072;

    logic          clk;
    logic          rst;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;
    logic          tvalid;
    logic          tlast;
    logic          tuser;
    logic          wr_en;
    logic          full;
    FIFO_PCIECFG_T din;
    logic [31:0]   stat_ok;
    logic [31:0]   stat_drop;

    pciecfg_rx #(
        .LOCAL_IP (LIP),
        .UDP_PORT (LPORT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .eth_rx_tdata         (tdata),
        .eth_rx_tkeep         (tkeep),
        .eth_rx_tvalid        (tvalid),
        .eth_rx_tlast         (tlast),
        .eth_rx_tuser         (tuser),
        .fifo_pciecfg_i_wr_en (wr_en),
        .fifo_pciecfg_i_full  (full),
        .fifo_pciecfg_i_din   (din),
        .stat_rx_ok           (stat_ok),
        .stat_rx_drop         (stat_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ethertype;
        logic [7:0]  verihl;
        logic [7:0]  proto;
        logic [31:0] dip;
        logic [15:0] dport;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [15:0] sport;
        logic [7:0]  op;
        logic [7:0]  mask;
        logic [15:0] dw;
        logic [31:0] data;
        int unsigned len;
        logic        tuser;
        logic        full;
    } frm_t;

    typedef struct {
        logic          accept;
        FIFO_PCIECFG_T din;
    } exp_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_writes = 0;
    exp_t        exp_q[$];
    logic        synced;
    int unsigned m_ok;
    int unsigned m_drop;
    logic        prev_last = 1'b0;
    logic [7:0]  fb [64];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp(input int unsigned v);
`ifdef PCIECFG_RX_STATS_EN
        return v;
`else
        return (v == 0) ? 32'h0 : 32'h0;
`endif
    endfunction

    function automatic frm_t mk_valid(input logic [7:0] op);
        frm_t f;
        f.ethertype = 16'h0800;
        f.verihl    = 8'h45;
        f.proto     = 8'd17;
        f.dip       = LIP;
        f.dport     = LPORT;
        f.smac      = {16'($urandom), $urandom};
        f.sip       = $urandom;
        f.sport     = 16'($urandom);
        f.op        = op;
        f.mask      = 8'($urandom);
        f.dw        = {6'd0, 10'($urandom)};
        f.data      = $urandom;
        f.len       = $urandom_range(50, 64);
        f.tuser     = 1'b0;
        f.full      = 1'b0;
        return f;
    endfunction

    task automatic build(input frm_t f);
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
        {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]} = f.smac;
        {fb[12], fb[13]} = f.ethertype;
        fb[14] = f.verihl;
        fb[23] = f.proto;
        {fb[26], fb[27], fb[28], fb[29]} = f.sip;
        {fb[30], fb[31], fb[32], fb[33]} = f.dip;
        {fb[34], fb[35]} = f.sport;
        {fb[36], fb[37]} = f.dport;
        fb[42] = f.op;
        fb[43] = f.mask;
        {fb[44], fb[45]} = f.dw;
        {fb[46], fb[47], fb[48], fb[49]} = f.data;
    endtask

    // Frame-level rule: everything must match and the frame must reach byte 49.
    task automatic model_frame(input frm_t f);
        exp_t e;
        logic good;
        good = (f.ethertype == 16'h0800) && (f.verihl == 8'h45) && (f.proto == 8'd17) &&
               (f.dip == LIP) && (f.dport == LPORT) && (f.dw[15:10] == 6'd0) &&
               (f.op == 8'h00 || f.op == 8'h01) && (f.len >= 50) && !f.tuser && !f.full;
        e.accept = synced && good;
        e.din = '0;
        if (e.accept) begin
            e.din.data_valid    = 1'b1;
            e.din.pkt.src_mac   = f.smac;
            e.din.pkt.src_ip    = f.sip;
            e.din.pkt.src_port  = f.sport;
            e.din.pkt.opcode    = f.op;
            e.din.pkt.byte_mask = f.mask[3:0];
            e.din.pkt.dwaddr    = f.dw[9:0];
            e.din.pkt.data      = f.data;
        end
        if (!synced) synced = 1'b1;
        else if (e.accept) m_ok++;
        else m_drop++;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle();
        tvalid = 1'b0;
        tdata  = {$urandom, $urandom};
        tkeep  = 8'($urandom);
        tlast  = 1'($urandom);
        tuser  = 1'($urandom);
        full   = 1'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic send(input frm_t f, input int unsigned gap_max, input int unsigned stop_beats);
        int unsigned nb;
        build(f);
        nb = (f.len + 7) / 8;
        for (int k = 0; k < int'(nb); k++) begin
            if (stop_beats != 0 && k == int'(stop_beats)) return;
            if (k > 0) repeat ($urandom_range(0, gap_max)) idle_cycle();
            for (int i = 0; i < 8; i++) begin
                if (8 * k + i < int'(f.len)) begin
                    tdata[8*i +: 8] = fb[8*k+i];
                    tkeep[i] = 1'b1;
                end else begin
                    tdata[8*i +: 8] = 8'($urandom);
                    tkeep[i] = 1'b0;
                end
            end
            tvalid = 1'b1;
            tlast  = (k == int'(nb) - 1);
            tuser  = tlast ? f.tuser : 1'b0;
            full   = tlast ? f.full : 1'($urandom);
            if (tlast) model_frame(f);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        synced = 1'b0;
        m_ok   = 0;
        m_drop = 0;
        check_eq("rst_wr_en", 256'(wr_en), 256'(0));
        check_eq("rst_din", 256'(din), 256'(0));
        check_eq("rst_stat_ok", 256'(stat_ok), 256'(0));
        check_eq("rst_stat_drop", 256'(stat_drop), 256'(0));
        rst = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        repeat (3) idle_cycle();
        check_eq({tag, "_ok"}, 256'(stat_ok), 256'(stat_exp(m_ok)));
        check_eq({tag, "_drop"}, 256'(stat_drop), 256'(stat_exp(m_drop)));
    endtask

    // Each tlast beat is answered on the next cycle: write (as predicted) or nothing.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_last = 1'b0;
        end else begin
            if (prev_last) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL model_queue: got empty expected entry");
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_en", 256'(wr_en), 256'(e.accept));
                    if (e.accept && wr_en) begin
                        check_eq("din", 256'(din), 256'(e.din));
                        n_writes++;
                    end
                end
            end else begin
                check_eq("wr_idle", 256'(wr_en), 256'(0));
            end
            prev_last = tvalid && tlast;
        end
    end

    initial begin
        frm_t f;
        int unsigned w0;
        rst = 1'b1;
        tdata = '0;
        tkeep = '0;
        tvalid = 1'b0;
        tlast = 1'b0;
        tuser = 1'b0;
        full = 1'b0;
        synced = 1'b0;
        m_ok = 0;
        m_drop = 0;
        @(posedge clk); #1;

        // Reset, partial frame, reset mid-frame, junk frame, then a read.
        do_reset();
        send(mk_valid(PCIECFG_OPC_RD), 1, 3);
        do_reset();
        send(mk_valid(PCIECFG_OPC_RD), 1, 0);
        f = mk_valid(PCIECFG_OPC_RD);
        f.dw = 16'h0004;
        send(f, 1, 0);
        check_stats("s1");
        check_eq("s1_ok_count", 256'(m_ok), 256'(1));

        // Write frame with full byte mask.
        do_reset();
        send(mk_valid(PCIECFG_OPC_WR), 0, 0);
        f = mk_valid(PCIECFG_OPC_WR);
        f.mask = 8'h0F;
        f.dw   = 16'h0010;
        f.data = 32'hDEADBEEF;
        send(f, 1, 0);
        check_stats("s2");

        // Header mismatches.
        do_reset();
        send(mk_valid(PCIECFG_OPC_RD), 0, 0);
        f = mk_valid(PCIECFG_OPC_WR); f.dport = 16'd3073;        send(f, 1, 0);
        f = mk_valid(PCIECFG_OPC_WR); f.dip = 32'hC0A8_0A02;     send(f, 1, 0);
        f = mk_valid(PCIECFG_OPC_WR); f.ethertype = 16'h86DD;    send(f, 1, 0);
        f = mk_valid(8'h07);                                     send(f, 1, 0);
        check_stats("s3");

        // Errored tail and runt.
        do_reset();
        send(mk_valid(PCIECFG_OPC_RD), 0, 0);
        f = mk_valid(PCIECFG_OPC_WR); f.tuser = 1'b1;            send(f, 1, 0);
        f = mk_valid(PCIECFG_OPC_WR); f.len = 40;                send(f, 1, 0);
        check_stats("s4");

        // FIFO full at tlast, then back-to-back frame with room.
        do_reset();
        send(mk_valid(PCIECFG_OPC_RD), 0, 0);
        f = mk_valid(PCIECFG_OPC_WR); f.full = 1'b1;             send(f, 0, 0);
        send(mk_valid(PCIECFG_OPC_RD), 0, 0);
        check_stats("s5");

        // Three frames with no gaps.
        do_reset();
        send(mk_valid(PCIECFG_OPC_RD), 0, 0);
        w0 = n_writes;
        send(mk_valid(PCIECFG_OPC_RD), 0, 0);
        send(mk_valid(PCIECFG_OPC_WR), 0, 0);
        send(mk_valid(PCIECFG_OPC_RD), 0, 0);
        check_stats("s6");
        check_eq("s6_writes", 256'(n_writes - w0), 256'(3));

        // Random mix of valid and faulty frames, random gaps.
        do_reset();
        send(mk_valid(PCIECFG_OPC_RD), 2, 0);
        for (int n = 0; n < 80; n++) begin
            f = mk_valid(8'($urandom_range(0, 1)));
            case ($urandom_range(0, 15))
                0: f.ethertype ^= 16'(1 << $urandom_range(0, 15));
                1: f.verihl ^= 8'(1 << $urandom_range(0, 7));
                2: f.proto ^= 8'(1 << $urandom_range(0, 7));
                3: f.dip ^= 32'(1 << $urandom_range(0, 31));
                4: f.dport ^= 16'(1 << $urandom_range(0, 15));
                5: f.dw[15:10] = 6'($urandom_range(1, 63));
                6: f.op = 8'($urandom_range(2, 255));
                7: f.len = $urandom_range(1, 48);
                8: f.tuser = 1'b1;
                9: f.full = 1'b1;
                default: ;
            endcase
            send(f, 2, 0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        check_stats("rand");
        check_eq("rand_queue_drained", 256'(exp_q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
